ahb_req_arbiter: RTL and testbench
==================================

# ahb_req_arbiter

Round-robin arbiter and sequencer that shares one `ahb_master` among `NREQ` local requesters. Grants one requester at a time and drives the master's command inputs (`enable`, `addr`, `WR`, `data_in_1/2`, `slave_sel`) through exactly one transfer. Checks `Hready_out` in the data phase and retries a bounded number of times. Returns read data and a one-cycle completion pulse to the granted requester.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `MAX_RETRY`, 3: data-phase retries allowed before the transfer completes with an error
- `Hclk` in 1: clock
- `Hreset` in 1: one clock; reset is synchronous and active-high
- `req` in NREQ: request level; held high until the matching `ack` bit pulses
- `req_wr` in NREQ: 1 = write, 0 = read
- `req_addr` in 32·NREQ: packed addresses; requester i occupies bits [32i+31:32i]
- `req_d1`, `req_d2` in 32·NREQ: packed write operands; the master writes their sum
- `req_sel` in 2·NREQ: packed slave select
- `gnt` out NREQ: one-hot grant; all zeros when idle
- `ack` out NREQ: one-cycle completion pulse
- `ack_err` out 1: valid with `ack`; 1 = retries exhausted
- `rdata` out 32: read result; valid with `ack` for reads; holds its value otherwise
- `m_enable`, `m_wr` out 1: to master `enable` / `WR`
- `m_addr`, `m_d1`, `m_d2` out 32: to master `addr` / `data_in_1` / `data_in_2`
- `m_sel` out 2: to master `slave_sel`
- `m_dout` in 32: from master `d_out`
- `Hready_out` in 1: slave ready, same net the master sees

## Operation
- States:
  - IDLE: pick the winner.
  - ISSUE: `m_enable`=1 for this cycle only.
  - ADDR: master is in its address state.
  - DATA: master is in s2 (write) or s3 (read).
  - DONE: complete the transfer.
- IDLE → ISSUE when any `req` bit is high.
  - The winner is the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - Latch the winner's index into `gnt`.
  - Latch the winner's wr, addr, d1, d2 and sel into command registers. These drive the `m_*` outputs until DONE.
- ISSUE → ADDR → DATA unconditionally.
- DATA, `Hready_out`=1 → DONE with err=0.
- DATA, `Hready_out`=0:
  - If `retry_cnt` < `MAX_RETRY`: increment `retry_cnt` and go to ISSUE.
  - Otherwise go to DONE with err=1.
- DONE:
  - Pulse `ack[gnt]` and drive `ack_err`.
  - On a read with err=0, load `rdata` from `m_dout`.
  - Set `rr_ptr` to (granted index + 1) mod NREQ.
  - Clear `retry_cnt` and `gnt`.
  - Go to IDLE.
- Requests arriving mid-transfer wait for IDLE. A requester dropping `req` mid-transfer does not abort it; `ack` still pulses.
- Simultaneous requests resolve purely by `rr_ptr`. The grant is never re-evaluated before DONE.
- Reset in any state:
  - State → IDLE, `rr_ptr`=0, `retry_cnt`=0.
  - All outputs 0: `gnt`, `ack`, `ack_err`, `rdata`, `m_*`.
  - Top level ties master `Hresetn` = ~`Hreset`, so both reset together.

## Timing
- Transfer starts with ISSUE at cycle T. The master reaches s1 at T+1 and s2/s3 at T+2 (DATA). `Hready_out` is sampled at the end of T+2.
- No retry: master returns to idle at T+3 (DONE). `ack` pulses at T+3 and `rdata` is valid from T+4.
- Each retry adds 3 cycles: ISSUE re-enters at T+3, while the master is idle.
- Request-to-ack latency with no retries: 4 cycles from the cycle `req` is first sampled high in IDLE.
- Back-to-back transfers: one transfer per 5 cycles.
- `m_enable` is high only in ISSUE, so the master never sees `enable` during s2/s3 and always returns to idle.
- `m_*` command outputs are stable from ISSUE through DONE.

## Structure
- Package `ahb_ctrl_pkg` holds:
  - the state enum (IDLE=0, ISSUE=1, ADDR=2, DATA=3, DONE=4), 3-bit;
  - the address and data width constants (32);
  - the slave-select width (2).
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req`[NREQ], `ptr`.
  - Outputs: one-hot `gnt_next`, `idx_next`, `any`.
- The top module holds the FSM, command registers, `retry_cnt` and `rr_ptr`.

## Test plan
- Single write: requester 1 writes addr=0x10, d1=5, d2=7, sel=1 with `Hready_out`=1 → `m_enable` high 1 cycle, `m_addr`=0x10, `m_wr`=1, `ack`=4'b0010 four cycles after request, `ack_err`=0.
- Read: requester 0 reads, `m_dout`=0xDEADBEEF during DATA → `rdata`=0xDEADBEEF the cycle after `ack`.
- Contention: `req`=4'b1111 held → grant order 0,1,2,3,0, one `ack` every 5 cycles.
- Retry: `Hready_out`=0 in the first two DATA phases, then 1 → three ISSUE cycles, `ack` at T+9, err=0.
- Exhaustion: `Hready_out` stuck 0 → 4 DATA phases, then `ack` with `ack_err`=1 and `rdata` unchanged.
- Reset during DATA → next cycle all outputs 0, state IDLE, `rr_ptr`=0; the following request from requester 2 is granted normally.

Source files
------------

// File: rtl/ahb_req_arbiter_pkg.sv
// Shared types and widths for the AHB requester arbiter: FSM state encoding,
// bus widths and the round-robin pointer wrap helper.
package ahb_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int ptr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// Requester-side and master-side signal bundle of the arbiter; the slave
// modport is the arbiter's view, the master modport is its environment's view.
interface ahb_req_arbiter_if
  import ahb_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [ADDR_W*NREQ-1:0] req_addr;
  logic [DATA_W*NREQ-1:0] req_d1;
  logic [DATA_W*NREQ-1:0] req_d2;
  logic [SEL_W*NREQ-1:0]  req_sel;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic                   ack_err;
  logic [DATA_W-1:0]      rdata;
  logic                   m_enable;
  logic                   m_wr;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_d1;
  logic [DATA_W-1:0]      m_d2;
  logic [SEL_W-1:0]       m_sel;
  logic [DATA_W-1:0]      m_dout;
  logic                   Hready_out;

  modport slave (
    input  req, req_wr, req_addr, req_d1, req_d2, req_sel, m_dout, Hready_out,
    output gnt, ack, ack_err, rdata, m_enable, m_wr, m_addr, m_d1, m_d2, m_sel
  );

  modport master (
    output req, req_wr, req_addr, req_d1, req_d2, req_sel, m_dout, Hready_out,
    input  gnt, ack, ack_err, rdata, m_enable, m_wr, m_addr, m_d1, m_d2, m_sel
  );

endinterface

// File: rtl/ahb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// scanning upward with wrap-around.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt_next,
  output logic [$clog2(NREQ)-1:0] idx_next,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] w_pos;

  always_comb begin
    gnt_next = '0;
    idx_next = '0;
    any      = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = PW'((int'(ptr) + k) % NREQ);
      if (!any && req[w_pos]) begin
        any             = 1'b1;
        idx_next        = w_pos;
        gnt_next[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter that sequences one shared ahb_master through a single
// transfer per grant, with bounded data-phase retries.
module ahb_req_arbiter
  import ahb_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic             Hclk,
  input  logic             Hreset,
  ahb_req_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_next;
  logic [PW-1:0]     r_idx, r_ptr, w_idx_next;
  logic              w_any, w_retry_ok;
  logic [RW-1:0]     r_retry;
  logic              r_err, r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_d1, r_d2, r_rdata;
  logic [SEL_W-1:0]  r_sel;

  logic [ADDR_W-1:0] w_addr_arr [NREQ];
  logic [DATA_W-1:0] w_d1_arr   [NREQ];
  logic [DATA_W-1:0] w_d2_arr   [NREQ];
  logic [SEL_W-1:0]  w_sel_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_arr[g] = bus.req_addr[ADDR_W*g +: ADDR_W];
    assign w_d1_arr[g]   = bus.req_d1[DATA_W*g +: DATA_W];
    assign w_d2_arr[g]   = bus.req_d2[DATA_W*g +: DATA_W];
    assign w_sel_arr[g]  = bus.req_sel[SEL_W*g +: SEL_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (bus.req),
    .ptr      (r_ptr),
    .gnt_next (w_gnt_next),
    .idx_next (w_idx_next),
    .any      (w_any)
  );

  assign w_retry_ok = int'(r_retry) < MAX_RETRY;

  always_ff @(posedge Hclk) begin
    if (Hreset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_ADDR;
      ST_ADDR:  w_state_nxt = ST_DATA;
      ST_DATA:  w_state_nxt = (bus.Hready_out || !w_retry_ok) ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Command registers are captured once per grant and held through DONE so the
  // master sees stable inputs across every retry of the same transfer.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_gnt  <= w_gnt_next;
          r_idx  <= w_idx_next;
          r_wr   <= bus.req_wr[w_idx_next];
          r_addr <= w_addr_arr[w_idx_next];
          r_d1   <= w_d1_arr[w_idx_next];
          r_d2   <= w_d2_arr[w_idx_next];
          r_sel  <= w_sel_arr[w_idx_next];
          r_err  <= 1'b0;
        end
        ST_DATA: begin
          if (bus.Hready_out) r_err   <= 1'b0;
          else if (w_retry_ok) r_retry <= r_retry + RW'(1);
          else                 r_err   <= 1'b1;
        end
        ST_DONE: begin
          if (!r_wr && !r_err) r_rdata <= bus.m_dout;
          r_ptr   <= PW'(ptr_wrap_inc(int'(r_idx), NREQ));
          r_retry <= '0;
          r_gnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.ack      = (r_state == ST_DONE) ? r_gnt : '0;
  assign bus.ack_err  = (r_state == ST_DONE) && r_err;
  assign bus.rdata    = r_rdata;
  assign bus.m_enable = (r_state == ST_ISSUE);
  assign bus.m_wr     = r_wr;
  assign bus.m_addr   = r_addr;
  assign bus.m_d1     = r_d1;
  assign bus.m_d2     = r_d2;
  assign bus.m_sel    = r_sel;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed-vector bench for ahb_req_arbiter with a queue-based scoreboard that
// checks every ack against its expected requester, error flag, cycle and rdata.
module tb_ahb_req_arbiter;
  import ahb_ctrl_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 3;

  logic Hclk   = 1'b0;
  logic Hreset = 1'b1;

  ahb_req_arbiter_if #(.NREQ(NREQ)) bus ();

  ahb_req_arbiter #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  always #5 Hclk = ~Hclk;

  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic            err;
    int              at;
    logic [31:0]     rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks    = 0;
  int          failures  = 0;
  int          ack_cnt   = 0;
  int          en_cnt    = 0;
  logic [31:0] mdl_rdata = '0;
  logic        pend      = 1'b0;
  logic [31:0] pend_rd   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: counts ISSUE cycles and scores every ack against the queue head.
  always @(negedge Hclk) begin
    if (bus.m_enable) en_cnt++;
    if (pend) begin
      chk("rdata", bus.rdata, pend_rd);
      pend = 1'b0;
    end
    if (bus.ack != '0) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", bus.ack, '0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_vec", bus.ack, mon_e.ack);
        chk("ack_err", bus.ack_err, mon_e.err);
        chk("ack_cycle", cyc, mon_e.at);
        pend    = 1'b1;
        pend_rd = mon_e.rdata;
      end
    end
  end

  task automatic push_exp(input int idx, input logic err, input int at,
                          input logic rd, input logic [31:0] dout);
    exp_t e;
    e.ack = '0;
    e.ack[idx] = 1'b1;
    e.err = err;
    e.at  = at;
    if (rd && !err) mdl_rdata = dout;
    e.rdata = mdl_rdata;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] s);
    bus.req_wr[i]          = wr;
    bus.req_addr[i*32 +: 32] = a;
    bus.req_d1[i*32 +: 32]   = d1;
    bus.req_d2[i*32 +: 32]   = d2;
    bus.req_sel[i*2 +: 2]    = s;
  endtask

  task automatic wait_acks(input int start, input int n, input int maxc);
    for (int k = 0; k < maxc && ack_cnt < start + n; k++) @(posedge Hclk);
    if (ack_cnt < start + n) chk("ack_timeout", ack_cnt, start + n);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, '0);
    chk({tag, "_ack"}, bus.ack, '0);
    chk({tag, "_ack_err"}, bus.ack_err, '0);
    chk({tag, "_rdata"}, bus.rdata, '0);
    chk({tag, "_m_enable"}, bus.m_enable, '0);
    chk({tag, "_m_wr"}, bus.m_wr, '0);
    chk({tag, "_m_addr"}, bus.m_addr, '0);
    chk({tag, "_m_d1"}, bus.m_d1, '0);
    chk({tag, "_m_d2"}, bus.m_d2, '0);
    chk({tag, "_m_sel"}, bus.m_sel, '0);
  endtask

  int c0;
  int a0;

  initial begin
    bus.req        = '0;
    bus.req_wr     = '0;
    bus.req_addr   = '0;
    bus.req_d1     = '0;
    bus.req_d2     = '0;
    bus.req_sel    = '0;
    bus.m_dout     = '0;
    bus.Hready_out = 1'b1;
    step(3);
    chk_zero("rst0");
    Hreset = 1'b0;
    step(1);

    // Contention: all four held, order 0,1,2,3,0 every 5 cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 32'(i), 32'h1, 2'(i));
    c0 = cyc; a0 = ack_cnt;
    bus.req = 4'b1111;
    push_exp(0, 1'b0, c0 + 4,  1'b0, '0);
    push_exp(1, 1'b0, c0 + 9,  1'b0, '0);
    push_exp(2, 1'b0, c0 + 14, 1'b0, '0);
    push_exp(3, 1'b0, c0 + 19, 1'b0, '0);
    push_exp(0, 1'b0, c0 + 24, 1'b0, '0);
    wait_acks(a0, 5, 40);
    bus.req = '0;
    step(2);

    // Single write from requester 1.
    set_req(1, 1'b1, 32'h10, 32'd5, 32'd7, 2'd1);
    bus.m_dout = 32'h12345678;
    c0 = cyc; a0 = ack_cnt; en_cnt = 0;
    bus.req[1] = 1'b1;
    push_exp(1, 1'b0, c0 + 4, 1'b0, bus.m_dout);
    step(2);
    chk("wr_gnt", bus.gnt, 4'b0010);
    chk("wr_m_addr", bus.m_addr, 32'h10);
    chk("wr_m_wr", bus.m_wr, 1'b1);
    chk("wr_m_d1", bus.m_d1, 32'd5);
    chk("wr_m_d2", bus.m_d2, 32'd7);
    chk("wr_m_sel", bus.m_sel, 2'd1);
    chk("wr_m_enable_addr", bus.m_enable, 1'b0);
    wait_acks(a0, 1, 12);
    bus.req = '0;
    chk("wr_issue_cnt", en_cnt, 1);
    step(1);

    // Read from requester 0.
    set_req(0, 1'b0, 32'h20, 32'd0, 32'd0, 2'd2);
    bus.m_dout = 32'hDEADBEEF;
    c0 = cyc; a0 = ack_cnt;
    bus.req[0] = 1'b1;
    push_exp(0, 1'b0, c0 + 4, 1'b1, 32'hDEADBEEF);
    wait_acks(a0, 1, 12);
    bus.req = '0;
    step(1);

    // Retry: two not-ready data phases, then ready.
    set_req(3, 1'b1, 32'h30, 32'd1, 32'd2, 2'd3);
    bus.Hready_out = 1'b0;
    c0 = cyc; a0 = ack_cnt; en_cnt = 0;
    bus.req[3] = 1'b1;
    push_exp(3, 1'b0, c0 + 10, 1'b0, '0);
    step(9);
    bus.Hready_out = 1'b1;
    wait_acks(a0, 1, 12);
    bus.req = '0;
    chk("retry_issue_cnt", en_cnt, 3);
    step(1);

    // Exhaustion: read with ready stuck low; rdata must not change.
    set_req(2, 1'b0, 32'h40, 32'd0, 32'd0, 2'd0);
    bus.m_dout = 32'hCAFEF00D;
    bus.Hready_out = 1'b0;
    c0 = cyc; a0 = ack_cnt; en_cnt = 0;
    bus.req[2] = 1'b1;
    push_exp(2, 1'b1, c0 + 13, 1'b1, 32'hCAFEF00D);
    wait_acks(a0, 1, 20);
    bus.req = '0;
    bus.Hready_out = 1'b1;
    chk("exh_issue_cnt", en_cnt, 4);
    step(1);

    // Reset while in DATA.
    set_req(1, 1'b1, 32'h50, 32'd3, 32'd4, 2'd1);
    c0 = cyc;
    bus.req[1] = 1'b1;
    step(3);
    Hreset  = 1'b1;
    bus.req = '0;
    step(1);
    chk_zero("rst1");
    Hreset    = 1'b0;
    mdl_rdata = '0;
    step(1);

    // After reset the pointer is 0, so 2 beats 3 when both request.
    set_req(2, 1'b1, 32'h60, 32'd8, 32'd9, 2'd2);
    set_req(3, 1'b1, 32'h70, 32'd1, 32'd1, 2'd3);
    c0 = cyc; a0 = ack_cnt;
    bus.req = 4'b1100;
    push_exp(2, 1'b0, c0 + 4, 1'b0, '0);
    push_exp(3, 1'b0, c0 + 9, 1'b0, '0);
    wait_acks(a0, 1, 12);
    bus.req[2] = 1'b0;
    wait_acks(a0, 2, 12);
    bus.req = '0;
    step(3);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
